// File: rtl/nzp_cc_unit.sv
// ============================================================================
//  Module   : nzp_cc_unit
//  Brief    : N/Z/P condition-code register with branch evaluation and a
//             save/restore stack for interrupt entry/RTI.
//             Optional NZP_BR_REG_EN: registers br_taken (1-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nzp_cc_unit #(
    parameter int         DATA_W      = 16,
    parameter int         STACK_DEPTH = 4,
    parameter logic [2:0] RESET_NZP   = 3'b010,
    localparam int        CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] buss,
    input  logic              push,
    input  logic              pop,
    input  logic              br_en,
    input  logic [2:0]        br_mask,
    output logic              N,
    output logic              Z,
    output logic              P,
    output logic              br_taken,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam logic [CNT_W-1:0] c_max_depth = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic [2:0]       r_nzp;
    logic [CNT_W-1:0] r_depth;
    logic             r_err;
    logic [2:0]       r_stack [STACK_DEPTH];

    logic             w_n;
    logic             w_z;
    logic             w_p;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_illegal;
    logic             w_br;
    logic [2:0]       w_top;

    // Bus classification: the three terms are mutually exclusive by construction.
    assign w_n = buss[DATA_W-1];
    assign w_z = (buss == '0);
    assign w_p = ~w_n & ~w_z;

    assign w_full  = (r_depth == c_max_depth);
    assign w_empty = (r_depth == '0);

    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_illegal = (push & pop) | (push & ~pop & w_full) | (pop & ~push & w_empty);

    // Top-of-stack read mux, entry depth-1.
    always_comb begin
        w_top = RESET_NZP;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == CNT_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Any pop request (legal or not) blocks flag_we for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nzp   <= RESET_NZP;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_illegal;
            if (w_pop_ok) begin
                r_nzp   <= w_top;
                r_depth <= r_depth - c_one;
            end else begin
                if (flag_we && !pop) begin
                    r_nzp <= {w_n, w_z, w_p};
                end
                if (w_push_ok) begin
                    r_depth <= r_depth + c_one;
                end
            end
        end
    end

    // Stack storage needs no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!reset && w_push_ok && (r_depth == CNT_W'(i))) begin
                r_stack[i] <= r_nzp;
            end
        end
    end

    assign w_br = br_en & |(br_mask & r_nzp);

`ifdef NZP_BR_REG_EN
    logic r_br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_taken <= 1'b0;
        end else begin
            r_br_taken <= w_br;
        end
    end

    assign br_taken = r_br_taken;
`else
    assign br_taken = w_br;
`endif

    assign N     = r_nzp[2];
    assign Z     = r_nzp[1];
    assign P     = r_nzp[0];
    assign depth = r_depth;
    assign full  = w_full;
    assign empty = w_empty;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nzp_cc_unit.sv
// ============================================================================
//  Module   : tb_nzp_cc_unit
//  Brief    : Directed self-checking bench for nzp_cc_unit (both br_taken builds).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nzp_cc_unit;

    logic        clk;
    logic        reset;
    logic        flag_we;
    logic [15:0] buss;
    logic        push;
    logic        pop;
    logic        br_en;
    logic [2:0]  br_mask;
    logic        N;
    logic        Z;
    logic        P;
    logic        br_taken;
    logic [2:0]  depth;
    logic        full;
    logic        empty;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    nzp_cc_unit #(
        .DATA_W      (16),
        .STACK_DEPTH (4),
        .RESET_NZP   (3'b010)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flag_we  (flag_we),
        .buss     (buss),
        .push     (push),
        .pop      (pop),
        .br_en    (br_en),
        .br_mask  (br_mask),
        .N        (N),
        .Z        (Z),
        .P        (P),
        .br_taken (br_taken),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset   = 1'b0;
        flag_we = 1'b0;
        buss    = 16'h0000;
        push    = 1'b0;
        pop     = 1'b0;
        br_en   = 1'b0;
        br_mask = 3'b000;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        push  = 1'b1;
        tick();
        idle();
        n_checks++; if ({N, Z, P} !== 3'b010) begin n_fail++; $display("FAIL reset_nzp: got %b expected 010", {N, Z, P}); end
        n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        n_checks++; if ({empty, full, err} !== 3'b100) begin n_fail++; $display("FAIL reset_empty_full_err: got %b expected 100", {empty, full, err}); end
    endtask

    task automatic test_classify();
        logic [15:0] vec [4];
        logic [2:0]  exp [4];
        vec[0] = 16'h8000; exp[0] = 3'b100;
        vec[1] = 16'h0000; exp[1] = 3'b010;
        vec[2] = 16'h0001; exp[2] = 3'b001;
        vec[3] = 16'h7FFF; exp[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            flag_we = 1'b1;
            buss    = vec[i];
            if (i == 0) begin
                #1;
                n_checks++; if ({N, Z, P} !== 3'b010) begin n_fail++; $display("FAIL classify_latency: got %b expected 010", {N, Z, P}); end
            end
            tick();
            n_checks++; if ({N, Z, P} !== exp[i]) begin n_fail++; $display("FAIL classify_%h: got %b expected %b", vec[i], {N, Z, P}, exp[i]); end
        end
        idle();
    endtask

    task automatic test_branch();
        logic       en   [4];
        logic [2:0] mask [4];
        logic       exp  [4];
        en[0] = 1'b1; mask[0] = 3'b001; exp[0] = 1'b1;
        en[1] = 1'b1; mask[1] = 3'b110; exp[1] = 1'b0;
        en[2] = 1'b1; mask[2] = 3'b000; exp[2] = 1'b0;
        en[3] = 1'b0; mask[3] = 3'b111; exp[3] = 1'b0;
        flag_we = 1'b1;
        buss    = 16'h0001;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            br_en   = en[i];
            br_mask = mask[i];
`ifdef NZP_BR_REG_EN
            tick();
`else
            #1;
`endif
            n_checks++; if (br_taken !== exp[i]) begin n_fail++; $display("FAIL branch_%0d_en%b_mask%b: got %b expected %b", i, en[i], mask[i], br_taken, exp[i]); end
`ifndef NZP_BR_REG_EN
            tick();
`endif
        end
        // Same-cycle flag write must not affect the decision.
        br_en   = 1'b1;
        br_mask = 3'b111;
        flag_we = 1'b1;
        buss    = 16'h8000;
`ifdef NZP_BR_REG_EN
        tick();
`else
        #1;
`endif
        n_checks++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL branch_mask111: got %b expected 1", br_taken); end
        idle();
        flag_we = 1'b1;
        buss    = 16'h0001;
        tick();
        idle();
        br_en   = 1'b1;
        br_mask = 3'b100;
`ifdef NZP_BR_REG_EN
        tick();
`else
        #1;
`endif
        n_checks++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL branch_n_on_p: got %b expected 0", br_taken); end
        idle();
        tick();
    endtask

    task automatic test_stack_sequence();
        flag_we = 1'b1; buss = 16'hFFFF;
        tick();
        n_checks++; if ({N, Z, P} !== 3'b100) begin n_fail++; $display("FAIL seq_ffff: got %b expected 100", {N, Z, P}); end
        flag_we = 1'b1; buss = 16'h0000; push = 1'b1;
        tick();
        flag_we = 1'b1; buss = 16'h0005; push = 1'b1;
        tick();
        idle();
        n_checks++; if ({N, Z, P} !== 3'b001 || depth !== 3'd2) begin n_fail++; $display("FAIL seq_after_push: got nzp=%b depth=%0d expected nzp=001 depth=2", {N, Z, P}, depth); end
        pop = 1'b1;
        tick();
        n_checks++; if ({N, Z, P} !== 3'b010 || depth !== 3'd1) begin n_fail++; $display("FAIL seq_pop1: got nzp=%b depth=%0d expected nzp=010 depth=1", {N, Z, P}, depth); end
        tick();
        idle();
        n_checks++; if ({N, Z, P} !== 3'b100 || depth !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL seq_pop2: got nzp=%b depth=%0d empty=%b expected nzp=100 depth=0 empty=1", {N, Z, P}, depth, empty); end
    endtask

    task automatic test_overflow_underflow();
        int pulses;
        flag_we = 1'b1; buss = 16'h0001;
        tick();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            push = 1'b1;
            if (i == 0) begin flag_we = 1'b1; buss = 16'h8000; end
            tick();
            if (err === 1'b1) pulses++;
            n_checks++; if (err !== (i == 4)) begin n_fail++; $display("FAIL overflow_err_push%0d: got %b expected %b", i + 1, err, (i == 4)); end
        end
        idle();
        n_checks++; if (depth !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL overflow_full: got depth=%0d full=%b expected depth=4 full=1", depth, full); end
        tick();
        if (err === 1'b1) pulses++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL overflow_pulse_count: got %0d expected 1", pulses); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            tick();
            n_checks++; if (depth !== 3'(3 - i) || err !== 1'b0) begin n_fail++; $display("FAIL pop%0d: got depth=%0d err=%b expected depth=%0d err=0", i + 1, depth, err, 3 - i); end
        end
        pop = 1'b1; flag_we = 1'b1; buss = 16'h0000;
        tick();
        idle();
        n_checks++; if (err !== 1'b1 || depth !== 3'd0) begin n_fail++; $display("FAIL underflow: got err=%b depth=%0d expected err=1 depth=0", err, depth); end
        n_checks++; if ({N, Z, P} !== 3'b001) begin n_fail++; $display("FAIL underflow_flags: got %b expected 001", {N, Z, P}); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL underflow_err_clear: got %b expected 0", err); end
    endtask

    task automatic test_illegal();
        flag_we = 1'b1; buss = 16'h0000;
        tick();
        idle(); push = 1'b1;
        tick();
        flag_we = 1'b1; buss = 16'h0001; push = 1'b1;
        tick();
        idle();
        push = 1'b1; pop = 1'b1; flag_we = 1'b1; buss = 16'h8000;
        tick();
        idle();
        n_checks++; if (depth !== 3'd2 || {N, Z, P} !== 3'b001 || err !== 1'b1) begin n_fail++; $display("FAIL push_pop: got depth=%0d nzp=%b err=%b expected depth=2 nzp=001 err=1", depth, {N, Z, P}, err); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL push_pop_err_clear: got %b expected 0", err); end
        pop = 1'b1; flag_we = 1'b1; buss = 16'h8000;
        tick();
        idle();
        n_checks++; if ({N, Z, P} !== 3'b010 || depth !== 3'd1) begin n_fail++; $display("FAIL pop_over_we: got nzp=%b depth=%0d expected nzp=010 depth=1", {N, Z, P}, depth); end
        pop = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        flag_we = 1'b1; buss = 16'h0001;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            tick();
        end
        n_checks++; if (depth !== 3'd3) begin n_fail++; $display("FAIL reset_mid_setup: got depth=%0d expected 3", depth); end
        push = 1'b1; reset = 1'b1; flag_we = 1'b1; buss = 16'h8000;
        tick();
        idle();
        n_checks++; if (depth !== 3'd0 || {N, Z, P} !== 3'b010 || err !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reset_mid: got depth=%0d nzp=%b err=%b empty=%b expected 0 010 0 1", depth, {N, Z, P}, err, empty); end
    endtask

    initial begin
        idle();
        test_reset();
        test_classify();
        test_branch();
        test_stack_sequence();
        test_overflow_underflow();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
